fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write arbiter that shares one `sync_fifo` write port among NREQ producers. Each producer offers one word at a time with a req/ack handshake. The arbiter grants bursts of up to MAX_BURST words per owner and drives the FIFO's `wr_en`/`data_in` directly. It back-pressures every producer while the FIFO reports `full`.

## Interface
- `NREQ`, default 4: number of requesters; legal range is 2..16.
- `WIDTH`, default 16: data word width; must match the downstream FIFO.
- `MAX_BURST`, default 4: maximum consecutive beats per grant; legal range is 1..255.
- `IDW` (localparam): equals `$clog2(NREQ)`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  bit i: requester i has a valid word on its data slice.
- `req_data`  in  NREQ*WIDTH  requester i's word is at bits [i*WIDTH +: WIDTH].
- `ack`  out  NREQ  one-hot or zero, combinational: the word of requester i is written this cycle.
- `fifo_full`  in  1  full flag from the FIFO.
- `fifo_wr_en`  out  1  combinational; equals the OR of `ack`.
- `fifo_data_in`  out  WIDTH (WIDTH+IDW with tag, see Configuration)  selected word.
- `busy`  out  1  registered; high while in BURST.
- `owner`  out  IDW  registered; index of the current or last owner.

## Operation
- Handshake: a requester raises `req` and holds `req` and its data stable until it sees `ack`. `ack` is high for exactly one cycle per accepted word. The requester may present the next word in the cycle after `ack`, or keep `req` high for back-to-back words.
- State `rr_last` (IDW bits) records the last owner. Search order starts at `rr_last+1` and wraps modulo NREQ.
- FSM state IDLE:
  - If `fifo_full`=1 or `req`=0: no ack, stay in IDLE, `rr_last` unchanged.
  - Otherwise the first requesting index in search order wins. Its word is accepted in this same cycle, `owner` is set to the winner and `cnt` is set to 1.
  - Next state is BURST, or IDLE if MAX_BURST=1. When returning to IDLE, `rr_last` is set to the winner.
- FSM state BURST:
  - Only `owner` can be acked.
  - `req[owner]`=1 and `fifo_full`=0: accept and increment `cnt`. If `cnt` reaches MAX_BURST, go to IDLE and set `rr_last`=`owner`.
  - `req[owner]`=1 and `fifo_full`=1: no ack, hold state and `cnt`.
  - `req[owner]`=0: no ack this cycle. Go to IDLE and set `rr_last`=`owner`. This costs one bubble cycle.
- Requests from non-owners during BURST are ignored and wait their turn. No requester can starve: a waiting requester is granted within NREQ-1 bursts.
- `cnt` is 8 bits wide and saturates at MAX_BURST; it never wraps.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - State is IDLE, `cnt`=0, `owner`=0, `busy`=0, `rr_last`=NREQ-1, so requester 0 wins first.
  - `ack`, `fifo_wr_en` and `fifo_data_in` are all 0.
- Accept latency: zero cycles. Ack and FIFO write happen in the cycle the arbiter selects the requester, gated by the current `fifo_full`.
- Handoff after a completed burst has no bubble: the IDLE cycle that follows itself accepts the next winner.
- Handoff after the owner drops `req` costs one bubble cycle.
- `fifo_full` rising mid-burst stalls without losing the grant. Writing stops in the same cycle `full` is seen.
- Reset mid-burst aborts the burst immediately. Words already acked stay in the FIFO; the word on the bus is not written.
- `fifo_data_in` is 0 whenever `fifo_wr_en`=0.

## Configuration
- `FIFO_ARB_SRC_TAG_EN` defined:
  - `fifo_data_in` is WIDTH+IDW bits wide, laid out as {source index, word}.
  - The downstream FIFO must be instantiated with WIDTH+IDW.
- Not defined: `fifo_data_in` is WIDTH bits and carries the word only.

## Test plan
- Reset arbitration: NREQ=4, MAX_BURST=4, all `req`=1 continuously, FIFO never full → ack sequence is 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,… with no gap cycles.
- Single requester: only `req[2]`=1 for 10 words → 10 consecutive acks to requester 2. `busy` is low for one cycle after each 4-beat burst, with no bubble.
- Owner drop: requester 1 sends 2 words then drops `req` while `req[3]`=1 → one bubble cycle, then requester 3 is acked. `owner`=3 and `busy`=1 the following cycle.
- Full stall: `sync_fifo` DEPTH=8 (7 usable entries), no reads, all requesting → exactly 7 acks, then `fifo_wr_en`=0 while `full`=1. After one read, exactly one more ack goes to the stalled owner.
- Reset mid-burst: pulse `rst_n` low after the 2nd beat of a burst → `ack`/`busy`/`owner` are 0 immediately. After release, requester 0 wins first.
- Tag build with `FIFO_ARB_SRC_TAG_EN` defined: requester 3 writes 16'hBEEF → FIFO output reads 18'h3BEEF.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bus of fifo_wr_arbiter.
// Define FIFO_ARB_SRC_TAG_EN to widen fifo_data_in to {source index, word}.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned IDW = $clog2(NREQ);
`ifdef FIFO_ARB_SRC_TAG_EN
  localparam int unsigned DW = WIDTH + IDW;
`else
  localparam int unsigned DW = WIDTH;
`endif

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       ack;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [DW-1:0]         fifo_data_in;
  logic                  busy;
  logic [IDW-1:0]        owner;

  // Arbiter side
  modport master (
    input  req, req_data, fifo_full,
    output ack, fifo_wr_en, fifo_data_in, busy, owner
  );

  // Producers + FIFO side
  modport slave (
    output req, req_data, fifo_full,
    input  ack, fifo_wr_en, fifo_data_in, busy, owner
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NREQ producers.
// Zero-latency accept: ack/fifo_wr_en are combinational and gated by fifo_full.
// Define FIFO_ARB_SRC_TAG_EN to prefix each written word with its source index.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MAX_BURST = 4
) (
  input logic             clk,
  input logic             rst_n,
  fifo_wr_arbiter_if.master bus
);
  localparam int unsigned IDW = $clog2(NREQ);
  localparam logic [7:0]  MB8 = 8'(MAX_BURST);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_last_q, rr_last_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IDW-1:0]   cand, win, sel;
  logic             win_vld, accept;
  logic [NREQ-1:0]  ack_raw;
  logic [WIDTH-1:0] word;

  // Round-robin search from rr_last+1; iterating backwards leaves the nearest hit.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(rr_last_q) + k) % NREQ);
      if (bus.req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  // Next-state, burst counting and accept decision
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    sel       = owner_q;
    unique case (state_q)
      StIdle: begin
        if (!bus.fifo_full && win_vld) begin
          accept  = 1'b1;
          sel     = win;
          owner_d = win;
          cnt_d   = 8'd1;
          if (MAX_BURST == 1) begin
            rr_last_d = win;
          end else begin
            state_d = StBurst;
          end
        end
      end
      StBurst: begin
        if (!bus.req[owner_q]) begin
          // Owner went quiet: give up the grant, costs one bubble
          state_d   = StIdle;
          rr_last_d = owner_q;
        end else if (!bus.fifo_full) begin
          accept = 1'b1;
          cnt_d  = (cnt_q >= MB8) ? cnt_q : cnt_q + 8'd1;
          if (cnt_q + 8'd1 >= MB8) begin
            state_d   = StIdle;
            rr_last_d = owner_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs; reset also masks the combinational handshake
  always_comb begin
    ack_raw = '0;
    if (accept && rst_n) ack_raw[sel] = 1'b1;
    word             = bus.req_data[int'(sel)*WIDTH +: WIDTH];
    bus.ack          = ack_raw;
    bus.fifo_wr_en   = |ack_raw;
    bus.fifo_data_in = '0;
    if (|ack_raw) begin
`ifdef FIFO_ARB_SRC_TAG_EN
      bus.fifo_data_in = {sel, word};
`else
      bus.fifo_data_in = word;
`endif
    end
  end

  // State register; rr_last resets to NREQ-1 so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rr_last_q <= IDW'(NREQ - 1);
      owner_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.busy  = (state_q == StBurst);
  assign bus.owner = owner_q;
endmodule
